// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory slave between the I-cache refill
// master (port 0) and the D-cache master (port 1); steers read beats back to the issuer.
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BURSTLEN_WIDTH = 2
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [ADDR_WIDTH-1:0]     m0_addr,
   input  logic [BURSTLEN_WIDTH-1:0] m0_burst_len,
   input  logic                      m0_rd,
   input  logic                      m0_wr,
   input  logic [DATA_WIDTH-1:0]     m0_data_in,
   output logic                      m0_waitrequest,
   output logic [DATA_WIDTH-1:0]     m0_data_out,
   output logic                      m0_rd_valid,
   input  logic [ADDR_WIDTH-1:0]     m1_addr,
   input  logic [BURSTLEN_WIDTH-1:0] m1_burst_len,
   input  logic                      m1_rd,
   input  logic                      m1_wr,
   input  logic [DATA_WIDTH-1:0]     m1_data_in,
   output logic                      m1_waitrequest,
   output logic [DATA_WIDTH-1:0]     m1_data_out,
   output logic                      m1_rd_valid,
   output logic [ADDR_WIDTH-1:0]     s_addr,
   output logic [BURSTLEN_WIDTH-1:0] s_burst_len,
   output logic [DATA_WIDTH-1:0]     s_data_in,
   output logic                      s_rd,
   output logic                      s_wr,
   input  logic                      s_waitrequest,
   input  logic [DATA_WIDTH-1:0]     s_data_out,
   input  logic                      s_rd_valid
);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t                    state, state_next;
   logic                      owner, owner_next;
   logic                      last_grant, last_grant_next;
   logic [BURSTLEN_WIDTH:0]   beats_left, beats_left_next;

   logic                      req0, req1;
   logic                      grant_valid, grant_idx;
   logic                      sel_rd, sel_wr, accept;
   logic [BURSTLEN_WIDTH-1:0] sel_burst_len;

   assign req0 = m0_rd | m0_wr;
   assign req1 = m1_rd | m1_wr;

   // Grant is gated by reset_n so nothing reaches the slave while reset is held.
   always_comb begin
      grant_valid   = (state == IDLE) & (req0 | req1) & reset_n;
      grant_idx     = (req0 & req1) ? ~last_grant : req1;
      sel_rd        = grant_idx ? m1_rd : m0_rd;
      sel_wr        = grant_idx ? m1_wr : m0_wr;
      sel_burst_len = grant_idx ? m1_burst_len : m0_burst_len;
      accept        = grant_valid & ~s_waitrequest;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         beats_left <= '0;
      end else begin
         state      <= state_next;
         owner      <= owner_next;
         last_grant <= last_grant_next;
         beats_left <= beats_left_next;
      end
   end

   always_comb begin
      state_next      = state;
      owner_next      = owner;
      last_grant_next = last_grant;
      beats_left_next = beats_left;
      case (state)
         IDLE: begin
            if (accept) begin
               last_grant_next = grant_idx;
               if (sel_rd) begin
                  owner_next      = grant_idx;
                  beats_left_next = {1'b0, sel_burst_len} + {{BURSTLEN_WIDTH{1'b0}}, 1'b1};
                  state_next      = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (s_rd_valid) begin
               beats_left_next = beats_left - {{BURSTLEN_WIDTH{1'b0}}, 1'b1};
               if (beats_left == {{BURSTLEN_WIDTH{1'b0}}, 1'b1})
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A simultaneous rd+wr issues only the read; the write is dropped.
   always_comb begin
      s_addr         = grant_idx ? m1_addr : m0_addr;
      s_data_in      = grant_idx ? m1_data_in : m0_data_in;
      s_burst_len    = sel_burst_len;
      s_rd           = grant_valid & sel_rd;
      s_wr           = grant_valid & sel_wr & ~sel_rd;
      m0_waitrequest = ~(accept & ~grant_idx);
      m1_waitrequest = ~(accept & grant_idx);
      m0_data_out    = s_data_out;
      m1_data_out    = s_data_out;
      m0_rd_valid    = (state == RD_WAIT) & s_rd_valid & reset_n & ~owner;
      m1_rd_valid    = (state == RD_WAIT) & s_rd_valid & reset_n & owner;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: reset, round-robin grant, burst steering,
// write/read interleave, slave stall and mid-burst reset.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] m0_addr, m1_addr, m0_data_in, m1_data_in;
   logic [1:0]  m0_burst_len, m1_burst_len;
   logic        m0_rd, m0_wr, m1_rd, m1_wr;
   logic        m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid;
   logic [31:0] m0_data_out, m1_data_out;
   logic [31:0] s_addr, s_data_in, s_data_out;
   logic [1:0]  s_burst_len;
   logic        s_rd, s_wr, s_waitrequest, s_rd_valid;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURSTLEN_WIDTH(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_addr(m0_addr), .m0_burst_len(m0_burst_len), .m0_rd(m0_rd), .m0_wr(m0_wr),
      .m0_data_in(m0_data_in), .m0_waitrequest(m0_waitrequest),
      .m0_data_out(m0_data_out), .m0_rd_valid(m0_rd_valid),
      .m1_addr(m1_addr), .m1_burst_len(m1_burst_len), .m1_rd(m1_rd), .m1_wr(m1_wr),
      .m1_data_in(m1_data_in), .m1_waitrequest(m1_waitrequest),
      .m1_data_out(m1_data_out), .m1_rd_valid(m1_rd_valid),
      .s_addr(s_addr), .s_burst_len(s_burst_len), .s_data_in(s_data_in),
      .s_rd(s_rd), .s_wr(s_wr), .s_waitrequest(s_waitrequest),
      .s_data_out(s_data_out), .s_rd_valid(s_rd_valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Snapshot of the command-side outputs in one compact check.
   task automatic check_cmd(input string tag, input logic rd, input logic wr,
                            input logic w0, input logic w1);
      check({tag, " s_rd"}, 64'(s_rd), 64'(rd));
      check({tag, " s_wr"}, 64'(s_wr), 64'(wr));
      check({tag, " m0_wait"}, 64'(m0_waitrequest), 64'(w0));
      check({tag, " m1_wait"}, 64'(m1_waitrequest), 64'(w1));
   endtask

   initial begin
      reset_n = 1'b0;
      m0_addr = 32'h100; m0_burst_len = 2'd3; m0_rd = 1'b1; m0_wr = 1'b0; m0_data_in = '0;
      m1_addr = 32'h200; m1_burst_len = 2'd1; m1_rd = 1'b1; m1_wr = 1'b0; m1_data_in = '0;
      s_waitrequest = 1'b0; s_rd_valid = 1'b1; s_data_out = 32'hFFFF_0000;

      // Held in reset with both masters requesting and a stray beat on the bus
      step(); step();
      check_cmd("rst", 1'b0, 1'b0, 1'b1, 1'b1);
      check("rst m0_rd_valid", 64'(m0_rd_valid), 64'd0);
      check("rst m1_rd_valid", 64'(m1_rd_valid), 64'd0);

      // Release: m0 wins the first tie
      s_rd_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      check_cmd("tie", 1'b1, 1'b0, 1'b0, 1'b1);
      check("tie s_addr", 64'(s_addr), 64'h100);
      check("tie s_burst_len", 64'(s_burst_len), 64'd3);

      step();
      m0_rd = 1'b0;
      #1;
      check_cmd("rdwait", 1'b0, 1'b0, 1'b1, 1'b1);

      // Four beats to m0 with one idle gap; m1 keeps waiting
      for (int i = 0; i < 5; i++) begin
         s_rd_valid = (i != 2);
         s_data_out = 32'hC0DE_0000 + 32'(i);
         #1;
         check($sformatf("m0 beat%0d valid", i), 64'(m0_rd_valid), 64'(i != 2));
         if (i != 2) check($sformatf("m0 beat%0d data", i), 64'(m0_data_out), 64'hC0DE_0000 + 64'(i));
         check($sformatf("m0 beat%0d m1_valid", i), 64'(m1_rd_valid), 64'd0);
         check($sformatf("m0 beat%0d m1_wait", i), 64'(m1_waitrequest), 64'd1);
         step();
      end
      s_rd_valid = 1'b0;
      #1;
      // Cycle after m0's last beat: m1 accepted with its own address
      check_cmd("m1 grant", 1'b1, 1'b0, 1'b1, 1'b0);
      check("m1 grant s_addr", 64'(s_addr), 64'h200);
      step();
      m1_rd = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_rd_valid = 1'b1;
         s_data_out = 32'hBEEF_0000 + 32'(i);
         #1;
         check($sformatf("m1 beat%0d valid", i), 64'(m1_rd_valid), 64'd1);
         check($sformatf("m1 beat%0d data", i), 64'(m1_data_out), 64'hBEEF_0000 + 64'(i));
         check($sformatf("m1 beat%0d m0_valid", i), 64'(m0_rd_valid), 64'd0);
         step();
      end
      // Stray beat in IDLE is dropped
      #1;
      check("idle drop m0", 64'(m0_rd_valid), 64'd0);
      check("idle drop m1", 64'(m1_rd_valid), 64'd0);
      s_rd_valid = 1'b0;

      // Continuous writes from both masters alternate m0, m1, m0, m1
      m0_wr = 1'b1; m0_addr = 32'h10; m0_data_in = 32'hAAAA_0000;
      m1_wr = 1'b1; m1_addr = 32'h20; m1_data_in = 32'h5555_0000;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_cmd($sformatf("wr%0d", i), 1'b0, 1'b1, (i % 2) == 1, (i % 2) == 0);
         check($sformatf("wr%0d data", i), 64'(s_data_in),
               (i % 2) == 0 ? 64'hAAAA_0000 : 64'h5555_0000);
         step();
      end
      m0_wr = 1'b0; m1_wr = 1'b0;

      // m1 write held behind an m0 single-beat read
      m0_rd = 1'b1; m0_addr = 32'h300; m0_burst_len = 2'd0;
      m1_wr = 1'b1; m1_addr = 32'h40; m1_data_in = 32'hDEAD_BEEF;
      #1;
      check_cmd("mix grant", 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      m0_rd = 1'b0;
      #1;
      check_cmd("mix wait", 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      s_rd_valid = 1'b1; s_data_out = 32'h1234_5678;
      #1;
      check("mix beat valid", 64'(m0_rd_valid), 64'd1);
      check_cmd("mix beat", 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      s_rd_valid = 1'b0;
      #1;
      check_cmd("mix wr", 1'b0, 1'b1, 1'b1, 1'b0);
      check("mix wr addr", 64'(s_addr), 64'h40);
      check("mix wr data", 64'(s_data_in), 64'hDEAD_BEEF);
      step();
      m1_wr = 1'b0;

      // Slave stall for three cycles, then acceptance in the release cycle
      m1_rd = 1'b1; m1_addr = 32'h500; m1_burst_len = 2'd3;
      s_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_cmd($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b1, 1'b1);
         check($sformatf("stall%0d addr", i), 64'(s_addr), 64'h500);
         step();
      end
      s_waitrequest = 1'b0;
      #1;
      check_cmd("stall release", 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      m1_rd = 1'b0;
      s_rd_valid = 1'b1; s_data_out = 32'h0000_0001;
      #1;
      check("burst beat1", 64'(m1_rd_valid), 64'd1);
      step();

      // Reset mid-burst: remaining beats must not be forwarded
      reset_n = 1'b0;
      #1;
      check("midrst m1_valid", 64'(m1_rd_valid), 64'd0);
      check_cmd("midrst", 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      reset_n = 1'b1;
      #1;
      check("postrst m1_valid", 64'(m1_rd_valid), 64'd0);
      step();
      s_rd_valid = 1'b0;

      // Back in IDLE; rd+wr together issues only the read
      m0_rd = 1'b1; m0_wr = 1'b1; m0_addr = 32'h600; m0_burst_len = 2'd0;
      #1;
      check_cmd("rdwr", 1'b1, 1'b0, 1'b0, 1'b1);
      check("rdwr addr", 64'(s_addr), 64'h600);
      step();
      m0_rd = 1'b0; m0_wr = 1'b0;
      s_rd_valid = 1'b1; s_data_out = 32'h0000_0066;
      #1;
      check("rdwr beat", 64'(m0_rd_valid), 64'd1);
      step();
      s_rd_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
